// File: rtl/bus_responder.sv
// CPU-side bus slave: byte RAM, reset vector, and a memory-mapped output FIFO
// drained through a valid/ready port. Writes commit on the rising edge of the CPU phi2.
module bus_responder #(
  parameter int          RAM_AW       = 11,
  parameter logic [15:0] IO_BASE      = 16'hD000,
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        clk2,
  output logic [7:0]  rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int              PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              RAM_SIZE    = 1 << RAM_AW;
  localparam logic [16:0]     RAM_LIMIT   = 17'(RAM_SIZE);
  localparam logic [15:0]     STATUS_ADDR = IO_BASE + 16'd1;
  localparam logic [3:0]      DEPTH4      = 4'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR    = PW'(FIFO_DEPTH - 1);

  logic          clk2_q;
  logic          strobe;
  logic          wr_en;
  logic          in_ram;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          ovf_set;
  logic          ovf_clr;
  logic          overflow;
  logic [3:0]    count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    status;
  logic [7:0]    rd_next;

  logic [7:0] ram      [RAM_SIZE];
  logic [7:0] fifo_mem [FIFO_DEPTH];

  // History resets to 1 so a phi2 already high at release cannot look like a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clk2_q <= 1'b1;
    else        clk2_q <= clk2;
  end

  assign strobe = clk2 & ~clk2_q;
  assign wr_en  = strobe & ~rw;
  assign in_ram = ({1'b0, addr} < RAM_LIMIT);

  // Output handshake: a byte transfers on every clk where out_valid and out_ready are
  // both 1; out_data holds the FIFO head and stays put until that transfer happens.
  assign full      = (count == DEPTH4);
  assign empty     = (count == 4'd0);
  assign out_valid = ~empty;
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push_req  = wr_en & (addr == IO_BASE);
  assign push      = push_req & (~full | pop);
  assign ovf_set   = push_req & full & ~pop;
  assign ovf_clr   = wr_en & (addr == STATUS_ADDR);
  assign status    = {full, empty, overflow, 1'b0, count};

  always_ff @(posedge clk) begin
    if (wr_en && in_ram) ram[addr[RAM_AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      // A new overflow wins over a same-cycle clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_next = 8'h00;
    if (in_ram)                    rd_next = ram[addr[RAM_AW-1:0]];
    else if (addr == 16'hFFFC)     rd_next = RESET_VECTOR[7:0];
    else if (addr == 16'hFFFD)     rd_next = RESET_VECTOR[15:8];
    else if (addr == STATUS_ADDR)  rd_next = status;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= 8'h00;
    else if (rw) rdata <= rd_next;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: spec-level reference model checked every clk, a vector
// table for the address map, directed FIFO/reset sequences and random bus traffic.
module tb_bus_responder;

  localparam int          DEPTH = 8;
  localparam logic [15:0] IO    = 16'hD000;
  localparam logic [15:0] STAT  = 16'hD001;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rw;
  logic        clk2;
  logic [7:0]  rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state, expressed as a byte queue, a flag and a memory image.
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_prev;
  logic [7:0] m_ram   [2048];
  bit         m_known [2048];
  logic [7:0] m_rdata;
  bit         m_rd_known;

  typedef struct {
    bit          is_wr;
    logic [15:0] a;
    logic [7:0]  d;
  } vec_t;

  bus_responder #(
    .RAM_AW(11), .IO_BASE(16'hD000), .RESET_VECTOR(16'h1234), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rw(rw), .clk2(clk2),
    .rdata(rdata), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_read(input logic [15:0] a, output logic [7:0] d, output bit known);
    int n;
    n = m_q.size();
    known = 1'b1;
    d = 8'h00;
    if (a < 16'h0800) begin
      d = m_ram[a[10:0]];
      known = m_known[a[10:0]];
    end else if (a == 16'hFFFC) d = 8'h34;
    else if (a == 16'hFFFD) d = 8'h12;
    else if (a == STAT) d = {n == DEPTH, n == 0, m_ovf, 1'b0, 4'(n)};
  endfunction

  task automatic check_outputs();
    check("out_valid", {7'd0, out_valid}, {7'd0, m_q.size() != 0});
    if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
    if (m_rd_known) check("rdata", rdata, m_rdata);
  endtask

  // Called at a falling edge with inputs already driven; advances model and DUT one clk.
  task automatic tick();
    bit         strobe;
    bit         pop;
    bit         known;
    logic [7:0] d;
    int         n;
    strobe = clk2 && !m_prev;
    n = m_q.size();
    pop = (n != 0) && out_ready;
    if (rw) begin
      model_read(addr, d, known);
      m_rdata = d;
      m_rd_known = known;
    end
    if (pop) void'(m_q.pop_front());
    if (strobe && !rw) begin
      if (addr < 16'h0800) begin
        m_ram[addr[10:0]] = wdata;
        m_known[addr[10:0]] = 1'b1;
      end else if (addr == IO) begin
        if (n < DEPTH || pop) m_q.push_back(wdata);
        else m_ovf = 1'b1;
      end else if (addr == STAT) m_ovf = 1'b0;
    end
    m_prev = clk2;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; rw = 1'b0; clk2 = 1'b0;
    tick();
    clk2 = 1'b1;
    tick();
    clk2 = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr = a; rw = 1'b1; clk2 = 1'b0;
    tick();
    check(name, rdata, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_prev = 1'b1;
    m_rdata = 8'h00;
    m_rd_known = 1'b1;
  endtask

  // Pulses reset between edges; called at a falling edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    model_reset();
    #1 reset = 1'b1;
  endtask

  task automatic drain(output logic [7:0] last, output int popped);
    last = 8'h00;
    popped = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) begin
      last = out_data;
      popped++;
      tick();
    end
    check("drain_empty", {7'd0, out_valid}, 8'h00);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t       vecs[14];
    logic [7:0] last;
    int         popped;
    int         op;
    logic [15:0] ra;

    vecs[0]  = '{1'b1, 16'h0099, 8'h5A};
    vecs[1]  = '{1'b0, 16'h0099, 8'h5A};
    vecs[2]  = '{1'b0, 16'hFFFC, 8'h34};
    vecs[3]  = '{1'b0, 16'hFFFD, 8'h12};
    vecs[4]  = '{1'b0, 16'h0800, 8'h00};
    vecs[5]  = '{1'b0, 16'hD000, 8'h00};
    vecs[6]  = '{1'b1, 16'h07FF, 8'hC3};
    vecs[7]  = '{1'b0, 16'h07FF, 8'hC3};
    vecs[8]  = '{1'b1, 16'h0800, 8'h77};
    vecs[9]  = '{1'b0, 16'h0800, 8'h00};
    vecs[10] = '{1'b1, 16'hFFFC, 8'h99};
    vecs[11] = '{1'b0, 16'hFFFC, 8'h34};
    vecs[12] = '{1'b0, 16'hD001, 8'h40};
    vecs[13] = '{1'b0, 16'h0099, 8'h5A};

    // Clock/reset
    reset = 1'b1; clk2 = 1'b0; rw = 1'b1; addr = 16'h0000; wdata = 8'h00; out_ready = 1'b0;
    for (int i = 0; i < 2048; i++) m_known[i] = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rdata", rdata, 8'h00);
    check("reset_out_valid", {7'd0, out_valid}, 8'h00);
    #2 reset = 1'b1;
    @(negedge clk);

    // Address map vectors
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d);
      else rd($sformatf("vec%0d", i), vecs[i].a, vecs[i].d);
    end

    // Nine pushes into an 8-deep FIFO, then clear overflow
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(IO, 8'(i));
    rd("status_ovf", STAT, 8'hA8);
    check("head_01", out_data, 8'h01);
    wr(STAT, 8'h00);
    rd("status_clr", STAT, 8'h88);

    // Push into a full FIFO while popping in the same cycle
    addr = IO; wdata = 8'hAA; rw = 1'b0; clk2 = 1'b0;
    tick();
    clk2 = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; clk2 = 1'b0; rw = 1'b1;
    check("head_02", out_data, 8'h02);
    rd("status_full_swap", STAT, 8'h88);
    drain(last, popped);
    check("last_popped", last, 8'hAA);
    check("popped_cnt", 8'(popped), 8'd8);

    // Reset with three bytes queued and a would-be strobe waiting at release
    for (int i = 0; i < 3; i++) wr(IO, 8'hB0 + 8'(i));
    addr = 16'h0099; wdata = 8'hEE; rw = 1'b0; clk2 = 1'b1;
    do_reset();
    tick();
    clk2 = 1'b0; rw = 1'b1;
    rd("status_after_rst", STAT, 8'h40);
    rd("ram_kept", 16'h0099, 8'h5A);

    // Level-held phi2 gives a single write; low phi2 gives none
    out_ready = 1'b0;
    addr = IO; wdata = 8'h5C; rw = 1'b0; clk2 = 1'b0;
    tick();
    clk2 = 1'b1;
    repeat (4) tick();
    clk2 = 1'b0;
    repeat (3) tick();
    rw = 1'b1;
    rd("one_write", STAT, 8'h01);
    drain(last, popped);
    check("held_byte", last, 8'h5C);

    // Random bus traffic against the model
    for (int i = 0; i < 250; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 6);
      case (op)
        0: wr(16'($urandom_range(0, 16'h07FF)), 8'($urandom));
        1, 2: wr(IO, 8'($urandom));
        3: wr(STAT, 8'($urandom));
        4: wr(16'($urandom_range(16'h0800, 16'hCFFF)), 8'($urandom));
        default: begin
          case ($urandom_range(0, 4))
            0: ra = STAT;
            1: ra = 16'hFFFC;
            2: ra = 16'hFFFD;
            3: ra = 16'($urandom_range(0, 16'h07FF));
            default: ra = 16'($urandom_range(16'h0800, 16'hFFFB));
          endcase
          addr = ra; rw = 1'b1; clk2 = 1'b0;
          tick();
        end
      endcase
    end
    drain(last, popped);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_AW, default 11: RAM address width; RAM spans $0000..(2^RAM_AW)-1.
REQ-002 Parameter IO_BASE, default 16'hD000: base address of the output-port registers.
REQ-003 Parameter RESET_VECTOR, default 16'h0000: value returned at $FFFC (low byte) and $FFFD (high byte).
REQ-004 Parameter FIFO_DEPTH, default 8: output FIFO entries; a power of two, at most 8.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 addr  input  16  CPU address bus.
REQ-008 wdata  input  8  CPU write data; connects to the CPU odata output.
REQ-009 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-010 clk2  input  1  CPU phi2 phase output.
REQ-011 rdata  output  8  read data to the CPU; connects to the CPU idata input.
REQ-012 out_data  output  8  FIFO head byte.
REQ-013 out_valid  output  1  out_data holds a valid entry.
REQ-014 out_ready  input  1  consumer accepts out_data when out_valid is also 1.

Function
REQ-015 SHALL register clk2 every clk; a write strobe is phi2 sampled 1 with the previous sample 0.
REQ-016 A CPU write SHALL commit only on a write strobe with rw=0, using the addr and wdata present on that cycle.
REQ-017 A write to RAM range SHALL store wdata at addr[RAM_AW-1:0]; writes to unmapped addresses SHALL be ignored.
REQ-018 rdata SHALL update every clk while rw=1, one clk after addr, and SHALL hold while rw=0.
REQ-019 Reads SHALL return: RAM byte in RAM range; RESET_VECTOR[7:0] at $FFFC; RESET_VECTOR[15:8] at $FFFD; status at IO_BASE+1; $00 elsewhere, including IO_BASE.
REQ-020 Status SHALL be {full, empty, overflow, 1'b0, count[3:0]}, where count is 0..FIFO_DEPTH.
REQ-021 A write to IO_BASE SHALL push wdata when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-022 A push to a full FIFO without a same-cycle pop SHALL drop the byte and set the sticky overflow flag.
REQ-023 A write of any value to IO_BASE+1 SHALL clear overflow; a clear and a new overflow in the same cycle SHALL leave overflow set.
REQ-024 A pop SHALL occur on a cycle with out_valid=1 and out_ready=1; the next entry or out_valid=0 SHALL appear the following clk.
REQ-025 A push into an empty FIFO SHALL make out_valid=1 with that byte on the following clk (no bypass).
REQ-026 Simultaneous push and pop SHALL leave count unchanged and SHALL preserve FIFO order.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full = (count == FIFO_DEPTH); empty = (count == 0).
REQ-028 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 Reset assertion SHALL immediately force rdata=$00, out_valid=0, count=0, both pointers=0, overflow=0, and the clk2 history register=1.
REQ-030 RAM contents SHALL NOT be reset; FIFO storage contents are don't-care after reset.
REQ-031 Reset mid-operation SHALL discard all queued bytes and SHALL suppress any write strobe in the first clk after release.

Verification
REQ-032 Write $5A to $0099 on a clk2 rise, then read $0099 -> rdata=$5A one clk after addr is presented.
REQ-033 RESET_VECTOR=$1234: read $FFFC, then $FFFD -> rdata=$34, then $12; read $0800 -> $00.
REQ-034 out_ready=0, nine writes $01..$09 to $D000 -> status=$A8; out_data=$01; then write $D001 -> status=$88.
REQ-035 FIFO full, push $AA with out_ready=1 in the same cycle -> count stays 8, out_data advances $01->$02, $AA is the last byte popped, overflow=0.
REQ-036 Three bytes queued, pulse reset low between clk edges -> out_valid=0 immediately, status reads $40 after release, RAM $0099 still $5A.
REQ-037 rw=0 with clk2 held high for several clks -> exactly one write committed; rw=0 with clk2 low -> no write.
